// File: rtl/spk_unpack.sv
// Spike packet unpacker: fills a two-bank ping-pong store from indexed 128-bit beats and
// serialises each completed packet as a 32-bit word record with header and TLAST.
module spk_unpack #(
  parameter int unsigned SPK_LENTH = 19,
  parameter int unsigned WIDTH_CH  = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spk_stream_TVALID,
  input  logic [WIDTH_CH-1:0] spk_stream_CH,
  input  logic [31:0]         spk_stream_TIME,
  input  logic [15:0]         spk_stream_TDEST,
  input  logic [127:0]        spk_stream_TDATA,
  output logic                m_TVALID,
  input  logic                m_TREADY,
  output logic [31:0]         m_TDATA,
  output logic                m_TLAST,
  output logic [15:0]         seq_err_cnt,
  output logic [15:0]         ovf_cnt
);

  localparam int unsigned   IdxW     = (SPK_LENTH > 1) ? $clog2(SPK_LENTH) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(SPK_LENTH - 1);
  localparam logic [15:0]   LastDest = 16'(SPK_LENTH - 1);

  typedef enum logic [1:0] {WIdle, WFill, WDrop} w_state_e;
  typedef enum logic [1:0] {RIdle, RHdr0, RHdr1, RData} r_state_e;

  // Bank storage, not reset
  logic [127:0] mem_q  [2][SPK_LENTH];
  logic [WIDTH_CH-1:0] ch_q [2];
  logic [31:0]  time_q [2];

  w_state_e  w_state_q, w_state_d;
  r_state_e  r_state_q, r_state_d;
  logic [IdxW-1:0] exp_idx_q, exp_idx_d, r_beat_q, r_beat_d;
  logic [1:0]  r_lane_q, r_lane_d, bank_full_q, bank_full_d;
  logic        wb_q, wb_d, rb_q, rb_d;
  logic [15:0] seq_err_q, seq_err_d, ovf_q, ovf_d;
  logic        m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [31:0] m_tdata_q, m_tdata_d;

  logic            mem_we, hdr_we, start_eval, bank_set, bank_clr, fire, load;
  logic [IdxW-1:0] mem_waddr, nxt_beat;
  logic [1:0]      nxt_lane;
  logic [127:0]    rd_row;
  logic [11:0]     hdr_ch;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Writer
  always_comb begin
    w_state_d  = w_state_q;
    exp_idx_d  = exp_idx_q;
    wb_d       = wb_q;
    seq_err_d  = seq_err_q;
    ovf_d      = ovf_q;
    bank_set   = 1'b0;
    mem_we     = 1'b0;
    hdr_we     = 1'b0;
    mem_waddr  = exp_idx_q;
    start_eval = 1'b0;
    if (spk_stream_TVALID) begin
      unique case (w_state_q)
        WIdle: start_eval = 1'b1;
        WFill: begin
          if (spk_stream_TDEST == 16'(exp_idx_q)) begin
            mem_we = 1'b1;
            if (exp_idx_q == LastIdx) begin
              bank_set  = 1'b1;
              wb_d      = ~wb_q;
              w_state_d = WIdle;
            end else begin
              exp_idx_d = exp_idx_q + 1'b1;
            end
          end else begin
            seq_err_d = sat_inc(seq_err_q);
            if (spk_stream_TDEST == 16'd0) start_eval = 1'b1;
            else                           w_state_d  = WIdle;
          end
        end
        WDrop: begin
          if (spk_stream_TDEST == LastDest)   w_state_d  = WIdle;
          else if (spk_stream_TDEST == 16'd0) start_eval = 1'b1;
        end
        default: w_state_d = WIdle;
      endcase
      // Packet start evaluation, shared by idle, restart-in-fill and drop re-entry
      if (start_eval) begin
        if (spk_stream_TDEST != 16'd0) begin
          seq_err_d = sat_inc(seq_err_q);
        end else if (!bank_full_q[wb_q]) begin
          mem_we    = 1'b1;
          hdr_we    = 1'b1;
          mem_waddr = '0;
          exp_idx_d = IdxW'(1);
          w_state_d = WFill;
        end else begin
          ovf_d     = sat_inc(ovf_q);
          w_state_d = WDrop;
        end
      end
    end
  end

  // Reader
  always_comb begin
    r_state_d  = r_state_q;
    r_beat_d   = r_beat_q;
    r_lane_d   = r_lane_q;
    rb_d       = rb_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    bank_clr   = 1'b0;
    load       = 1'b0;
    nxt_beat   = r_beat_q;
    nxt_lane   = r_lane_q;
    fire       = m_tvalid_q & m_TREADY;
    hdr_ch     = 12'(ch_q[rb_q]);
    unique case (r_state_q)
      RIdle: if (bank_full_q[rb_q]) r_state_d = RHdr0;
      RHdr0: begin
        // One cycle with valid low before the header: the bank read is registered
        if (!m_tvalid_q) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = {4'b0, hdr_ch, 16'(SPK_LENTH)};
          m_tlast_d  = 1'b0;
        end else if (fire) begin
          r_state_d = RHdr1;
          m_tdata_d = time_q[rb_q];
        end
      end
      RHdr1: begin
        if (fire) begin
          r_state_d = RData;
          nxt_beat  = '0;
          nxt_lane  = 2'd0;
          load      = 1'b1;
        end
      end
      RData: begin
        if (fire) begin
          if (m_tlast_q) begin
            bank_clr   = 1'b1;
            rb_d       = ~rb_q;
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            r_state_d  = bank_full_q[~rb_q] ? RHdr0 : RIdle;
          end else begin
            nxt_lane = r_lane_q + 2'd1;
            if (r_lane_q == 2'd3) nxt_beat = r_beat_q + 1'b1;
            load = 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
    rd_row = mem_q[rb_q][nxt_beat];
    if (load) begin
      r_beat_d  = nxt_beat;
      r_lane_d  = nxt_lane;
      m_tlast_d = (nxt_beat == LastIdx) && (nxt_lane == 2'd3);
      unique case (nxt_lane)
        2'd0:    m_tdata_d = rd_row[127:96];
        2'd1:    m_tdata_d = rd_row[95:64];
        2'd2:    m_tdata_d = rd_row[63:32];
        default: m_tdata_d = rd_row[31:0];
      endcase
    end
  end

  // Commit and release always touch different banks
  always_comb begin
    bank_full_d = bank_full_q;
    if (bank_set) bank_full_d[wb_q] = 1'b1;
    if (bank_clr) bank_full_d[rb_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q   <= WIdle;
      r_state_q   <= RIdle;
      exp_idx_q   <= '0;
      r_beat_q    <= '0;
      r_lane_q    <= 2'd0;
      bank_full_q <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      seq_err_q   <= 16'd0;
      ovf_q       <= 16'd0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= 32'd0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      exp_idx_q   <= exp_idx_d;
      r_beat_q    <= r_beat_d;
      r_lane_q    <= r_lane_d;
      bank_full_q <= bank_full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      seq_err_q   <= seq_err_d;
      ovf_q       <= ovf_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tdata_q   <= m_tdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wb_q][mem_waddr] <= spk_stream_TDATA;
    if (hdr_we) begin
      ch_q[wb_q]   <= spk_stream_CH;
      time_q[wb_q] <= spk_stream_TIME;
    end
  end

  assign m_TVALID    = m_tvalid_q;
  assign m_TDATA     = m_tdata_q;
  assign m_TLAST     = m_tlast_q;
  assign seq_err_cnt = seq_err_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_spk_unpack.sv
// Scoreboard bench for spk_unpack: directed packets push expected records, a monitor pops
// and compares every output handshake and checks that stalled words hold steady.
module tb_spk_unpack;

  localparam int L = 19;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spk_stream_TVALID = 1'b0;
  logic [11:0]  spk_stream_CH = '0;
  logic [31:0]  spk_stream_TIME = '0;
  logic [15:0]  spk_stream_TDEST = '0;
  logic [127:0] spk_stream_TDATA = '0;
  logic         m_TVALID;
  logic         m_TREADY = 1'b0;
  logic [31:0]  m_TDATA;
  logic         m_TLAST;
  logic [15:0]  seq_err_cnt;
  logic [15:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;
  int words  = 0;
  logic [32:0] sb[$];
  logic rand_rdy  = 1'b0;
  logic rdy_fixed = 1'b0;
  logic stall_q   = 1'b0;
  logic [31:0] hold_data = '0;
  logic hold_last = 1'b0;

  spk_unpack #(.SPK_LENTH(L), .WIDTH_CH(12)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .spk_stream_TVALID (spk_stream_TVALID),
    .spk_stream_CH     (spk_stream_CH),
    .spk_stream_TIME   (spk_stream_TIME),
    .spk_stream_TDEST  (spk_stream_TDEST),
    .spk_stream_TDATA  (spk_stream_TDATA),
    .m_TVALID          (m_TVALID),
    .m_TREADY          (m_TREADY),
    .m_TDATA           (m_TDATA),
    .m_TLAST           (m_TLAST),
    .seq_err_cnt       (seq_err_cnt),
    .ovf_cnt           (ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Monitor: inputs change just after posedge, so negedge shows what the next edge will see
  always @(negedge clk) begin
    logic [32:0] exp_w;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!m_TVALID || m_TDATA !== hold_data || m_TLAST !== hold_last) begin
          errors++;
          $display("FAIL hold: got valid=%0b data=%h last=%0b, expected valid=1 data=%h last=%0b",
                   m_TVALID, m_TDATA, m_TLAST, hold_data, hold_last);
        end
      end
      if (m_TVALID && m_TREADY) begin
        checks++;
        words++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected word: got last=%0b data=%h, expected no output",
                   m_TLAST, m_TDATA);
        end else begin
          exp_w = sb.pop_front();
          if ({m_TLAST, m_TDATA} !== exp_w) begin
            errors++;
            $display("FAIL word %0d: got last=%0b data=%h, expected last=%0b data=%h",
                     words, m_TLAST, m_TDATA, exp_w[32], exp_w[31:0]);
          end
        end
      end
      stall_q   = m_TVALID && !m_TREADY;
      hold_data = m_TDATA;
      hold_last = m_TLAST;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mk(input int base, input int k);
    return {32'(base + k), 32'(base + k + 1), 32'(base + k + 2), 32'(base + k + 3)};
  endfunction

  function automatic void push_rec(input logic [11:0] ch, input logic [31:0] tm, input int base);
    sb.push_back({1'b0, 4'h0, ch, 16'(L)});
    sb.push_back({1'b0, tm});
    for (int k = 0; k < L; k++)
      for (int l = 0; l < 4; l++)
        sb.push_back({(k == L - 1) && (l == 3), 32'(base + k + l)});
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, " m_TVALID"}, 32'(m_TVALID), 32'd0);
    check_val({tag, " m_TLAST"}, 32'(m_TLAST), 32'd0);
    check_val({tag, " m_TDATA"}, m_TDATA, 32'd0);
    check_val({tag, " seq_err_cnt"}, 32'(seq_err_cnt), 32'd0);
    check_val({tag, " ovf_cnt"}, 32'(ovf_cnt), 32'd0);
  endtask

  task automatic beat(input logic [11:0] ch, input logic [31:0] tm, input int dest,
                      input logic [127:0] d);
    spk_stream_TVALID = 1'b1;
    spk_stream_CH     = ch;
    spk_stream_TIME   = tm;
    spk_stream_TDEST  = 16'(dest);
    spk_stream_TDATA  = d;
    @(posedge clk);
    #1;
    spk_stream_TVALID = 1'b0;
  endtask

  task automatic send_packet(input logic [11:0] ch, input logic [31:0] tm, input int base,
                             input bit gap);
    for (int k = 0; k < L; k++) begin
      if (gap && k == 5) begin
        repeat (2) @(posedge clk);
        #1;
      end
      // Later beats carry junk CH/TIME that must be ignored
      beat((k == 0) ? ch : ch + 12'd1, (k == 0) ? tm : tm + 32'd7, k, mk(base, k));
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d words left, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_room();
    int n = 0;
    while (sb.size() > 2 + 4 * L && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() > 2 + 4 * L) begin
      errors++;
      $display("FAIL room: got %0d words pending, expected at most %0d", sb.size(), 2 + 4 * L);
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single packet, latency and full record
    rdy_fixed = 1'b1;
    push_rec(12'd5, 32'd1000, 0);
    send_packet(12'd5, 32'd1000, 0, 1'b0);
    check_val("latency edge+0 valid", 32'(m_TVALID), 32'd0);
    @(posedge clk);
    #1;
    check_val("latency edge+1 valid", 32'(m_TVALID), 32'd0);
    @(posedge clk);
    #1;
    check_val("latency edge+2 valid", 32'(m_TVALID), 32'd1);
    check_val("first header", m_TDATA, 32'h0005_0013);
    wait_drain("single");

    // Three packets against a stalled reader: third one overflows
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_rec(12'd1, 32'd111, 100);
    push_rec(12'd2, 32'd222, 200);
    send_packet(12'd1, 32'd111, 100, 1'b0);
    send_packet(12'd2, 32'd222, 200, 1'b0);
    send_packet(12'd3, 32'd333, 300, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("ovf after third packet", 32'(ovf_cnt), 32'd1);
    check_val("seq_err after overflow", 32'(seq_err_cnt), 32'd0);
    rdy_fixed = 1'b1;
    wait_drain("overflow");

    // Index error 0..7 then 9: aborted without output
    for (int k = 0; k < 8; k++) beat(12'd7, 32'd700, k, mk(700, k));
    beat(12'd7, 32'd700, 9, mk(700, 9));
    repeat (3) @(posedge clk);
    #1;
    check_val("seq_err after skip", 32'(seq_err_cnt), 32'd1);
    push_rec(12'd8, 32'd800, 400);
    send_packet(12'd8, 32'd800, 400, 1'b0);
    wait_drain("after skip");
    check_val("ovf unchanged", 32'(ovf_cnt), 32'd1);

    // New packet start in mid-packet restarts with its own header
    for (int k = 0; k < 10; k++) beat(12'd9, 32'd77, k, mk(900, k));
    push_rec(12'd10, 32'd88, 500);
    send_packet(12'd10, 32'd88, 500, 1'b0);
    wait_drain("restart");
    check_val("seq_err after restart", 32'(seq_err_cnt), 32'd2);

    // Random back-pressure over ten packets, some with idle gaps
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_room();
      push_rec(12'(20 + i), 32'(5000 + i), 1000 + 10 * i);
      send_packet(12'(20 + i), 32'(5000 + i), 1000 + 10 * i, (i % 2) == 1);
    end
    wait_drain("random");
    rand_rdy = 1'b0;
    check_val("ovf after random", 32'(ovf_cnt), 32'd1);
    check_val("seq_err after random", 32'(seq_err_cnt), 32'd2);

    // Reset at beat 10 of a packet
    for (int k = 0; k < 10; k++) beat(12'd3, 32'd30, k, mk(3000, k));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset mid-packet");
    rst_n = 1'b1;
    push_rec(12'd11, 32'd1111, 2000);
    send_packet(12'd11, 32'd1111, 2000, 1'b0);
    wait_drain("after reset 1");

    // Reset during word 40 of a record
    push_rec(12'd12, 32'd1212, 2100);
    send_packet(12'd12, 32'd1212, 2100, 1'b0);
    n = 0;
    while (sb.size() > 2 + 4 * L - 40 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check_zero("reset mid-record");
    rst_n = 1'b1;
    push_rec(12'd13, 32'd1313, 2200);
    send_packet(12'd13, 32'd1313, 2200, 1'b0);
    wait_drain("after reset 2");
    check_val("final seq_err", 32'(seq_err_cnt), 32'd0);
    check_val("final ovf", 32'(ovf_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spk_unpack.md
SPK_UNPACK -- requirements
Module: spk_unpack

Interface
REQ-001 Parameter SPK_LENTH, default 19, beats per spike packet (19 for 25 kHz, 23 for 30 kHz).
REQ-002 Parameter WIDTH_CH, default 12, channel field width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 spk_stream_TVALID  input  1  beat valid; no ready back-pressure, every valid beat is consumed.
REQ-006 spk_stream_CH  input  WIDTH_CH  peak channel.
REQ-007 spk_stream_TIME  input  32  spike frame number.
REQ-008 spk_stream_TDEST  input  16  beat index 0..SPK_LENTH-1.
REQ-009 spk_stream_TDATA  input  128  four 32-bit samples, nn0 in [127:96] down to nn3 in [31:0].
REQ-010 m_TVALID  output  1  serialized word valid.
REQ-011 m_TREADY  input  1  downstream ready.
REQ-012 m_TDATA  output  32  serialized word.
REQ-013 m_TLAST  output  1  last word of a spike record.
REQ-014 seq_err_cnt  output  16  count of aborted packets (index error).
REQ-015 ovf_cnt  output  16  count of packets dropped for lack of a free bank.

Function
REQ-016 Two-bank ping-pong store, each bank SPK_LENTH x 128 bits plus CH and TIME registers; bank_full[1:0] flags, write pointer wb, read pointer rb.
REQ-017 Writer states W_IDLE, W_FILL, W_DROP; expected index exp_idx.
REQ-018 W_IDLE: valid beat with TDEST=0 and bank_full[wb]=0 -> store beat 0, latch CH/TIME, exp_idx=1, go W_FILL; TDEST=0 with bank_full[wb]=1 -> ovf_cnt+1, go W_DROP; TDEST!=0 -> seq_err_cnt+1, stay W_IDLE.
REQ-019 W_FILL: beat with TDEST=exp_idx -> store, exp_idx+1; when TDEST=SPK_LENTH-1 stored -> set bank_full[wb], toggle wb, go W_IDLE.
REQ-020 W_FILL: TDEST=0 -> seq_err_cnt+1, restart packet in same bank with this beat; any other mismatched TDEST -> seq_err_cnt+1, go W_IDLE.
REQ-021 W_DROP: discard beats; TDEST=SPK_LENTH-1 -> W_IDLE; TDEST=0 -> re-evaluate as W_IDLE.
REQ-022 Idle cycles (TVALID=0) inside a packet are legal and change no state.
REQ-023 CH/TIME of beat 0 define the record; later beats' CH/TIME ignored.
REQ-024 Reader states R_IDLE, R_HDR0, R_HDR1, R_DATA; leaves R_IDLE when bank_full[rb]=1.
REQ-025 Record order: HDR0 = {4'b0, CH zero-extended to 12 bits, 16-bit SPK_LENTH}; HDR1 = TIME; then for beat k=0..SPK_LENTH-1 words nn0,nn1,nn2,nn3; total 2+4*SPK_LENTH words (78 at default).
REQ-026 Word advances only on m_TVALID & m_TREADY; m_TDATA/m_TLAST held stable while m_TVALID=1 and m_TREADY=0.
REQ-027 m_TLAST=1 only on nn3 of beat SPK_LENTH-1; on its handshake clear bank_full[rb], toggle rb, go R_IDLE.
REQ-028 Latency: m_TVALID rises on the 2nd clk after the cycle the final beat is accepted (bank storage read registered).
REQ-029 Same-cycle writer commit and reader release on different banks both take effect; writer may start a new packet into a bank in the cycle after its release.
REQ-030 Back-to-back records: reader with next bank full goes from TLAST handshake directly to R_HDR0 without returning m_TVALID low for more than 1 cycle.
REQ-031 Counters saturate at 16'hFFFF.

Reset
REQ-032 rst_n=0 at a clk edge: writer W_IDLE, reader R_IDLE, wb=rb=0, bank_full=0, counters 0, m_TVALID=0, m_TLAST=0, m_TDATA=0; bank storage not cleared.
REQ-033 Reset mid-packet or mid-record discards all partial and pending data; first valid beat after release is evaluated per REQ-018.

Verification
REQ-034 One 19-beat packet, CH=5, TIME=1000, TDATA beat k = {k,k+1,k+2,k+3}, m_TREADY=1 -> 78 words: 0x0005_0013, 1000, 0,1,2,3,1,2,3,4,...; TLAST on word 78 only.
REQ-035 Three back-to-back packets with m_TREADY=0 -> first two stored, third dropped, ovf_cnt=1; then m_TREADY=1 -> two records in order.
REQ-036 Packet with TDEST sequence 0..7 then 9 -> seq_err_cnt=1, no output; following correct packet output intact.
REQ-037 Random m_TREADY toggling (50%) over 10 packets -> output matches scoreboard word-for-word, TDATA stable while stalled.
REQ-038 rst_n=0 for 1 cycle at beat 10 of a packet and during word 40 of a record -> all outputs/counters zero next cycle, next full packet produces a correct record.
REQ-039 Second packet with TDEST=0 arriving mid-packet -> seq_err_cnt+1, second packet output correctly with its own CH/TIME.
